// File: rtl/icu_pkg.sv
// Shared types for the MC14500B-style ICU instruction sequencer slice.
package icu_pkg;

  typedef enum logic [3:0] {
    NOPO = 4'h0, LD   = 4'h1, LDC  = 4'h2, AND  = 4'h3,
    ANDC = 4'h4, OR   = 4'h5, ORC  = 4'h6, XNOR = 4'h7,
    STO  = 4'h8, STOC = 4'h9, IEN  = 4'hA, OEN  = 4'hB,
    JMP  = 4'hC, RTN  = 4'hD, SKZ  = 4'hE, NOPF = 4'hF
  } instruction_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/icu_sequencer_if.sv
// Sequencer <-> ICU link: presented instruction/operand out, control strobes back.
interface icu_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  import icu_pkg::*;

  instruction_t      i;
  logic [ADDR_W-1:0] io_addr;
  logic              jmp;
  logic              rtn;
  logic              flag_f;

  modport master (output i, io_addr, input jmp, rtn, flag_f);
  modport slave  (input i, io_addr, output jmp, rtn, flag_f);

endinterface

// File: rtl/icu_ret_stack.sv
// LIFO of return addresses; dout always shows the top entry.
module icu_ret_stack #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);

  logic [PTR_W:0]    sp;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] mem [STACK_DEPTH];

  assign full    = (sp == (PTR_W+1)'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp[PTR_W-1:0] - 1'b1;
  assign dout    = mem[top_idx];

  // Only the pointer is reset; stale entries are unreachable once sp is 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[PTR_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/icu_sequencer.sv
// Program counter / fetch sequencer feeding an ICU, with JMP/RTN return stack.
module icu_sequencer
  import icu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W+3:0] prog_data,
  icu_sequencer_if.master   icu,
  output logic              running,
  output logic              halted,
  output logic              stk_err
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] io_q;
  instruction_t      i_q;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] ret_addr;

  assign pc_addr     = pc;
  assign icu.i       = i_q;
  assign icu.io_addr = io_q;

  // flag_f outranks jmp, jmp outranks rtn; a blocked strobe leaves the stack alone.
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    if (state == ST_RUN && !icu.flag_f) begin
      if (icu.jmp)      push = !full;
      else if (icu.rtn) pop  = !empty;
    end
  end

  icu_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc),
    .dout  (ret_addr),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      pc      <= '0;
      i_q     <= NOPO;
      io_q    <= '0;
      running <= 1'b0;
      halted  <= 1'b0;
      stk_err <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (icu.flag_f || icu.jmp || icu.rtn) begin
            i_q  <= NOPO;
            io_q <= '0;
          end else begin
            i_q  <= instruction_t'(prog_data[ADDR_W +: 4]);
            io_q <= prog_data[ADDR_W-1:0];
            pc   <= pc + 1'b1;
          end
          if (icu.flag_f) begin
            state   <= ST_HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if ((icu.jmp && full) || (!icu.jmp && icu.rtn && empty)) begin
            stk_err <= 1'b1;
            state   <= ST_HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if (icu.jmp) begin
            pc <= io_q;
          end else if (icu.rtn) begin
            pc <= ret_addr;
          end
        end
        default: begin
          i_q  <= NOPO;
          io_q <= '0;
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icu_sequencer.sv
// Self-checking bench for icu_sequencer: directed scenarios, then randomized ROM/strobes.
module tb_icu_sequencer;
  import icu_pkg::*;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] pc_addr;
  logic [AW+3:0] prog_data;
  logic          running;
  logic          halted;
  logic          stk_err;
  logic [AW+3:0] rom [256];

  icu_sequencer_if #(.ADDR_W(AW)) icu ();

  icu_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pc_addr   (pc_addr),
    .prog_data (prog_data),
    .icu       (icu),
    .running   (running),
    .halted    (halted),
    .stk_err   (stk_err)
  );

  assign prog_data = rom[pc_addr];
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit noise  = 1'b0;

  // Reference model: sequencer status as flags plus a queue for the return stack.
  bit           m_run, m_halt, m_err;
  logic [7:0]   m_pc, m_io;
  instruction_t m_i;
  logic [7:0]   q [$];

  function automatic logic [11:0] w(input instruction_t op, input logic [7:0] a);
    return {op, a};
  endfunction

  function automatic instruction_t op_at(input logic [7:0] a);
    logic [11:0] word;
    word = rom[a];
    return instruction_t'(word[11:8]);
  endfunction

  function automatic void model_reset();
    m_run = 1'b0; m_halt = 1'b0; m_err = 1'b0;
    m_pc = '0; m_io = '0; m_i = NOPO;
    q.delete();
  endfunction

  function automatic void model_step();
    logic [11:0] word;
    bit any;
    word = rom[m_pc];
    any  = icu.flag_f || icu.jmp || icu.rtn;
    if (m_run) begin
      if (icu.flag_f) begin
        m_run = 1'b0; m_halt = 1'b1;
      end else if (icu.jmp) begin
        if (q.size() == DEPTH) begin
          m_err = 1'b1; m_run = 1'b0; m_halt = 1'b1;
        end else begin
          q.push_back(m_pc);
          m_pc = m_io;
        end
      end else if (icu.rtn) begin
        if (q.size() == 0) begin
          m_err = 1'b1; m_run = 1'b0; m_halt = 1'b1;
        end else begin
          m_pc = q.pop_back();
        end
      end
      if (any) begin
        m_i = NOPO; m_io = '0;
      end else begin
        m_i  = instruction_t'(word[11:8]);
        m_io = word[7:0];
        m_pc = m_pc + 8'd1;
      end
    end else begin
      m_i = NOPO; m_io = '0;
      if (start) begin
        m_run = 1'b1; m_halt = 1'b0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_addr"}, 32'(pc_addr),     32'(m_pc));
    chk({tag, ".i"},       32'(icu.i),       32'(m_i));
    chk({tag, ".io_addr"}, 32'(icu.io_addr), 32'(m_io));
    chk({tag, ".running"}, 32'(running),     32'(m_run));
    chk({tag, ".halted"},  32'(halted),      32'(m_halt));
    chk({tag, ".stk_err"}, 32'(stk_err),     32'(m_err));
  endtask

  // Act as the ICU: raise the strobe matching the instruction now presented.
  task automatic drive_strobes();
    icu.jmp    = (m_i == JMP)  || (noise && $urandom_range(0, 19) == 0);
    icu.rtn    = (m_i == RTN)  || (noise && $urandom_range(0, 19) == 0);
    icu.flag_f = (m_i == NOPF) || (noise && $urandom_range(0, 29) == 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all("cyc");
    drive_strobes();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    start = 1'b0;
    icu.jmp = 1'b0; icu.rtn = 1'b0; icu.flag_f = 1'b0;
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rst = 1'b1;
  endtask

  task automatic run_until_op(input string tag, input instruction_t op, input int limit);
    int n = 0;
    while (m_i != op && n < limit) begin
      cycle();
      n++;
    end
    chk(tag, 32'(icu.i), 32'(op));
  endtask

  initial begin
    int n;
    icu.jmp = 1'b0; icu.rtn = 1'b0; icu.flag_f = 1'b0;
    for (int k = 0; k < 256; k++)
      rom[k] = w(instruction_t'(4'($urandom_range(1, 11))), 8'($urandom));
    rom[8'h00] = w(LD,   8'h00);
    rom[8'h01] = w(OR,   8'h01);
    rom[8'h02] = w(STO,  8'h02);
    rom[8'h03] = w(JMP,  8'h40);
    rom[8'h45] = w(RTN,  8'h00);
    rom[8'h10] = w(NOPF, 8'h00);
    rom[8'h11] = w(LDC,  8'h33);
    rom[8'h12] = w(JMP,  8'h50);
    rom[8'h50] = w(JMP,  8'h60);
    rom[8'h60] = w(JMP,  8'h70);
    rom[8'h70] = w(JMP,  8'h80);
    rom[8'h80] = w(JMP,  8'h90);
    rom[8'h81] = w(STO,  8'h07);

    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;
    cycle();
    cycle();
    chk("idle_pc_held", 32'(pc_addr), 32'h0);

    // Straight-line fetch after start
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("034_pc0", 32'(pc_addr), 32'h0);
    cycle(); chk("034_i_ld",  32'(icu.i), 32'(LD));  chk("034_pc1", 32'(pc_addr), 32'h1);
    cycle(); chk("034_i_or",  32'(icu.i), 32'(OR));  chk("034_pc2", 32'(pc_addr), 32'h2);
    cycle(); chk("034_i_sto", 32'(icu.i), 32'(STO)); chk("034_pc3", 32'(pc_addr), 32'h3);

    // Call to 0x40 and return to 4
    cycle(); chk("035_jmp", 32'(icu.i), 32'(JMP)); chk("035_io", 32'(icu.io_addr), 32'h40);
    cycle(); chk("035_bubble", 32'(icu.i), 32'(NOPO));
    cycle(); chk("035_target", 32'(icu.i), 32'(op_at(8'h40))); chk("035_running", 32'(running), 32'h1);
    run_until_op("036_rtn", RTN, 20);
    cycle(); chk("036_bubble", 32'(icu.i), 32'(NOPO)); chk("036_pc_ret", 32'(pc_addr), 32'h4);
    cycle(); chk("036_ret_i", 32'(icu.i), 32'(op_at(8'h04)));

    // NOPF halts and holds, start resumes at 0x11
    run_until_op("038_nopf", NOPF, 30);
    cycle(); chk("038_halted", 32'(halted), 32'h1); chk("038_pc", 32'(pc_addr), 32'h11);
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("038_hold_i", 32'(icu.i), 32'(NOPO));
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); chk("038_resume", 32'(icu.i), 32'(LDC));

    // Five nested calls overflow a 4-deep stack
    n = 0;
    while (!m_halt && n < 40) begin
      cycle();
      n++;
    end
    chk("037_halted", 32'(halted), 32'h1);
    chk("037_stk_err", 32'(stk_err), 32'h1);
    chk("037_pc", 32'(pc_addr), 32'h81);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); chk("037_resume", 32'(icu.i), 32'(STO)); chk("037_err_sticky", 32'(stk_err), 32'h1);

    // PC wrap and asynchronous reset mid-run
    n = 0;
    while (m_pc != 8'hFF && n < 300) begin
      cycle();
      n++;
    end
    chk("039_pc_ff", 32'(pc_addr), 32'hFF);
    cycle(); chk("039_wrap", 32'(pc_addr), 32'h00);
    cycle();
    do_reset("039_rst");
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); chk("030_restart", 32'(icu.i), 32'(LD));

    // Randomized programs, strobes, start and reset
    noise = 1'b1;
    for (int k = 0; k < 256; k++)
      rom[k] = w(instruction_t'(4'($urandom_range(0, 15))), 8'($urandom));
    do_reset("rnd_init");
    for (int k = 0; k < 3000; k++) begin
      start = ($urandom_range(0, 3) == 0);
      cycle();
      if ($urandom_range(0, 599) == 0) do_reset("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
